// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } hazardState_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int MDU_CYCLES_DEFAULT = 4;

    // Register $zero is never a real dependency, so a zero destination never matches.
    function automatic logic regHit(input logic wr, input logic [4:0] dst, input logic [4:0] src);
        return wr && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding select; the MEM producer is younger and wins over WB.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] exRs,
    input  logic [4:0] exRt,
    input  logic       memRegWrite,
    input  logic [4:0] memDst,
    input  logic       wbRegWrite,
    input  logic [4:0] wbDst,
    output logic [1:0] fwdA,
    output logic [1:0] fwdB
);

    always_comb begin
        fwdA = FWD_REG;
        fwdB = FWD_REG;
        if (regHit(memRegWrite, memDst, exRs)) begin
            fwdA = FWD_MEM;
        end else if (regHit(wbRegWrite, wbDst, exRs)) begin
            fwdA = FWD_WB;
        end
        if (regHit(memRegWrite, memDst, exRt)) begin
            fwdB = FWD_MEM;
        end else if (regHit(wbRegWrite, wbDst, exRt)) begin
            fwdB = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: data stalls, HI/LO busy tracking and branch flushes.
// Define HAZARD_FORWARD_EN to enable EX forwarding (only load-use then stalls).
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MDU_CYCLES = MDU_CYCLES_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_reads_hilo,
    input  logic        id_is_mdu,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_dst,
    input  logic        mem_reg_write,
    input  logic        wb_reg_write,
    input  logic [4:0]  mem_dst,
    input  logic [4:0]  wb_dst,
    input  logic        mdu_start,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mdu_busy,
    output logic [15:0] stall_count
);

    localparam logic [3:0] MDU_LOAD = 4'(MDU_CYCLES - 1);

    hazardState_e state, stateNext;
    logic [3:0]   count, countNext;
    logic         loadUse, dataStall, hiloStall, stall;

    // A load writes its destination by definition, so its read flag doubles as the write flag.
    always_comb begin
        loadUse = regHit(ex_mem_read, ex_dst, id_rs) ||
                  (id_uses_rt && regHit(ex_mem_read, ex_dst, id_rt));
    end

`ifdef HAZARD_FORWARD_EN
    logic unusedFwdBuild;
    assign unusedFwdBuild = ex_reg_write;

    forward_unit uForward (
        .exRs        (ex_rs),
        .exRt        (ex_rt),
        .memRegWrite (mem_reg_write),
        .memDst      (mem_dst),
        .wbRegWrite  (wb_reg_write),
        .wbDst       (wb_dst),
        .fwdA        (fwd_a),
        .fwdB        (fwd_b)
    );

    assign dataStall = loadUse;
`else
    logic unusedNoFwdBuild;
    assign unusedNoFwdBuild = ^{ex_rs, ex_rt, wb_reg_write, wb_dst};

    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;

    // WB producers need no stall: the register file writes before it reads.
    assign dataStall = loadUse ||
                       regHit(ex_reg_write, ex_dst, id_rs) ||
                       (id_uses_rt && regHit(ex_reg_write, ex_dst, id_rt)) ||
                       regHit(mem_reg_write, mem_dst, id_rs) ||
                       (id_uses_rt && regHit(mem_reg_write, mem_dst, id_rt));
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= RUN;
            count <= 4'd0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    // A mult/div arriving with a taken branch is younger than the branch and gets flushed.
    always_comb begin
        stateNext = state;
        countNext = count;
        case (state)
            RUN: begin
                if (mdu_start && !branch_taken) begin
                    stateNext = MDU_BUSY;
                    countNext = MDU_LOAD;
                end
            end
            MDU_BUSY: begin
                if (count == 4'd0) begin
                    stateNext = RUN;
                end else begin
                    countNext = count - 4'd1;
                end
            end
            default: begin
                stateNext = RUN;
                countNext = 4'd0;
            end
        endcase
    end

    always_comb begin
        mdu_busy    = (state == MDU_BUSY);
        hiloStall   = mdu_busy && (id_reads_hilo || id_is_mdu);
        stall       = (dataStall || hiloStall) && !branch_taken;
        pc_write    = !stall;
        ifid_write  = !stall;
        ifid_flush  = branch_taken;
        idex_flush  = stall || branch_taken;
        exmem_flush = branch_taken;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_count <= 16'd0;
        end else if (!pc_write && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule
